// File: rtl/mac_dot_unit_if.sv
// Operand/result handshake bundle for the dot-product MAC.
// The unit drives the slave side; producers/consumers use master.
interface mac_dot_unit_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
);
  logic signed [IN_W-1:0]  a;
  logic signed [IN_W-1:0]  b;
  logic                    valid_in;
  logic                    ready_in;
  logic signed [ACC_W-1:0] f;
  logic                    valid_out;
  logic                    ready_out;
  logic                    overflow;

  modport master (
    output a,
    output b,
    output valid_in,
    output ready_out,
    input  ready_in,
    input  f,
    input  valid_out,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    input  valid_in,
    input  ready_out,
    output ready_in,
    output f,
    output valid_out,
    output overflow
  );
endinterface

// File: rtl/mac_dot_unit.sv
// Pipelined signed MAC producing one dot product per VEC_LEN elements.
// Define MAC_SAT_EN for saturating accumulation (wraps otherwise).
module mac_dot_unit #(
  parameter int IN_W       = 8,
  parameter int ACC_W      = 16,
  parameter int VEC_LEN    = 4,
  parameter int MUL_STAGES = 1
) (
  input  logic         clk,
  input  logic         reset,
  mac_dot_unit_if.slave bus
);

  localparam int PW = 2 * IN_W;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  logic stall;

  logic                   in_v_q;
  logic signed [IN_W-1:0] a_q;
  logic signed [IN_W-1:0] b_q;

  logic signed [PW-1:0]    prod_full;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_p;
  logic                    acc_v;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ova_q, ova_d;
  logic signed [ACC_W-1:0] f_q, f_d;
  logic                    ovf_q, ovf_d;
  logic                    vout_q, vout_d;

  logic                    first;
  logic                    last;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ov;
  logic                    vec_ov;

  assign stall        = vout_q & ~bus.ready_out;
  assign bus.ready_in = ~stall;
  assign bus.f        = f_q;
  assign bus.overflow = ovf_q;
  assign bus.valid_out = vout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_v_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (!stall) begin
      in_v_q <= bus.valid_in;
      if (bus.valid_in) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
    end
  end

  assign prod_full = PW'(a_q) * PW'(b_q);
  assign prod_ext  = ACC_W'(prod_full);

  generate
    if (MUL_STAGES == 0) begin : g_nomul
      assign acc_p = prod_ext;
      assign acc_v = in_v_q;
    end else begin : g_mul
      logic signed [ACC_W-1:0] p_q [MUL_STAGES];
      logic [MUL_STAGES-1:0]   pv_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          pv_q <= '0;
          for (int i = 0; i < MUL_STAGES; i++) begin
            p_q[i] <= '0;
          end
        end else if (!stall) begin
          pv_q[0] <= in_v_q;
          p_q[0]  <= prod_ext;
          for (int i = 1; i < MUL_STAGES; i++) begin
            pv_q[i] <= pv_q[i-1];
            p_q[i]  <= p_q[i-1];
          end
        end
      end

      assign acc_p = p_q[MUL_STAGES-1];
      assign acc_v = pv_q[MUL_STAGES-1];
    end
  endgenerate

  // First element of a vector adds to zero, so load and add share one path
  assign first   = (cnt_q == '0);
  assign last    = (cnt_q == LAST);
  assign base    = first ? '0 : acc_q;
  assign sum_raw = base + acc_p;
  assign add_ov  = (base[ACC_W-1] == acc_p[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != base[ACC_W-1]);
  assign vec_ov  = (first ? 1'b0 : ova_q) | add_ov;

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  assign sum = add_ov ? (base[ACC_W-1] ? MINV : MAXV) : sum_raw;
`else
  assign sum = sum_raw;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    ova_d  = ova_q;
    f_d    = f_q;
    ovf_d  = ovf_q;
    vout_d = vout_q;
    if (!stall) begin
      vout_d = 1'b0;
      if (acc_v) begin
        if (last) begin
          f_d    = sum;
          ovf_d  = vec_ov;
          vout_d = 1'b1;
          cnt_d  = '0;
        end else begin
          acc_d = sum;
          ova_d = vec_ov;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      ova_q  <= 1'b0;
      f_q    <= '0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      ova_q  <= ova_d;
      f_q    <= f_d;
      ovf_q  <= ovf_d;
      vout_q <= vout_d;
    end
  end

endmodule

// File: doc/mac_dot_unit.md
# mac_dot_unit

Parametrised, pipelined signed multiply-accumulate unit computing fixed-length dot products. It accepts a stream of operand pairs, sums VEC_LEN consecutive products and emits one result per vector with a per-result overflow flag. It supports output backpressure and optional saturating arithmetic. It is the next-generation MAC for the neural-network datapath, feeding result collectors and activation stages downstream.

## Interface

Parameters:
- IN_W, 8, signed operand width.
- ACC_W, 16, accumulator/result width; must be >= 2*IN_W.
- VEC_LEN, 4, products per dot product; >= 1.
- MUL_STAGES, 1, extra register stages after the multiplier; 0..3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- a  in  IN_W  signed operand.
- b  in  IN_W  signed operand.
- valid_in  in  1  operand pair valid.
- ready_in  out  1  unit can accept an operand pair this cycle.
- f  out  ACC_W  signed dot-product result.
- valid_out  out  1  f/overflow valid.
- ready_out  in  1  downstream accepts the result.
- overflow  out  1  signed overflow occurred while accumulating this result.

## Operation

- Transfer rules:
  - An element is accepted when valid_in & ready_in.
  - A result is consumed when valid_out & ready_out.
- Pipeline:
  - Input register stage captures a and b on acceptance.
  - Combinational multiply into a 2*IN_W product, sign-extended to ACC_W.
  - MUL_STAGES product registers follow.
  - The accumulate stage comes last.
  - Each stage carries its own valid bit.
- Accumulate stage:
  - An element counter runs 0..VEC_LEN-1.
  - On count 0 the product is loaded, not added.
  - On count VEC_LEN-1 the sum (acc+p) is written to f, valid_out is set, and the counter wraps to 0.
  - With VEC_LEN=1, each product goes straight to f.
- Overflow:
  - Detected per ACC_W addition with the sign rule: operand signs equal and the sum sign differs.
  - Per-vector overflow is the OR over all additions in that vector, latched into overflow together with f.
  - It is cleared at the start of the next vector, so it is not sticky across results.
- Stall:
  - stall = valid_out & ~ready_out.
  - During a stall every pipeline stage, the counter, the partial accumulator, f and overflow hold.
  - ready_in = ~stall.
- Output release: valid_out clears after a consume unless a new result is written on the same edge, in which case it stays high with new data.
- Reset, including mid-vector:
  - f=0, overflow=0, valid_out=0.
  - All stage valids, the counter and the accumulator are cleared.
  - Any partial vector is discarded.
  - ready_in=1 from the first cycle after reset.

## Timing

- Element accepted at edge k lands in the accumulate stage; the last element of a vector produces valid_out=1 after edge k+1+MUL_STAGES, absent stalls.
- Throughput: one element per cycle. With continuous input, one result every VEC_LEN cycles.
- A stall adds exactly its length in cycles to all in-flight latency.
- A consume and a new result write on the same edge produce no bubble.
- valid_in gaps are allowed anywhere; partial sums persist across gaps.

## Configuration

- MAC_SAT_EN defined:
  - On overflow the accumulator clamps to 2^(ACC_W-1)-1 if both addends are non-negative, else to -2^(ACC_W-1).
  - Later additions start from the clamped value.
  - The overflow flag is still set.
- MAC_SAT_EN undefined: two's-complement wrap; the overflow flag is set identically.

## Test plan

Configuration for all tests: IN_W=8, ACC_W=16, VEC_LEN=4, MUL_STAGES=1, ready_out=1 unless noted.

- Basic latency:
  - Stimulus: a=1,2,3,4, b=2 on consecutive cycles, last accepted at edge k.
  - Response: f=20, overflow=0, valid_out high one cycle after edge k+2.
- Positive overflow:
  - Stimulus: four pairs a=127, b=127 (16129 each).
  - Response without MAC_SAT_EN: f=-1020, overflow=1.
  - Response with MAC_SAT_EN: f=32767, overflow=1.
- Negative overflow:
  - Stimulus: four pairs a=-128, b=127 (-16256 each).
  - Response without MAC_SAT_EN: f=512, overflow=1.
  - Response with MAC_SAT_EN: f=-32768, overflow=1.
- Backpressure:
  - Stimulus: hold ready_out=0 once the first result is valid while streaming the second vector.
  - Response: ready_in drops and f holds stable.
  - After ready_out=1, the second result appears with no data loss.
- Reset mid-vector:
  - Stimulus: assert reset after 2 elements, then send a=b=1 four times.
  - Response: f=4, overflow=0.
- Back-to-back and gaps:
  - Stimulus: an overflowing vector followed by a=b=1 x4 with random valid_in gaps.
  - Response: second result f=4, overflow=0.
